// File: rtl/seven_seg_reader.sv
// Seven-segment bus reader: samples a multiplexed active-low display bus,
// decodes each digit once it has settled, and publishes the BCD word after the
// whole display has repeated unchanged for STABLE_FRAMES complete frames.
module seven_seg_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    localparam int unsigned CntW   = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned StbW   = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned FrameW = 5 * NUM_DIGITS;
    localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE_CYCLES);
    localparam logic [StbW-1:0] StableMax = StbW'(STABLE_FRAMES);

    logic [6:0]                   seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]        an_q, an_prev_q;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic                         an_valid, same, capture;
    logic [3:0]                   dec_val;
    logic                         dec_err;
    logic [NUM_DIGITS-1:0][3:0]   slot_q, slot_d;
    logic [NUM_DIGITS-1:0]        slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]        mask_q, mask_d;
    logic [FrameW-1:0]            last_q, cur_frame;
    logic [StbW-1:0]              stable_q, stable_d;
    logic                         complete, frame_same, publish;
    logic [NUM_DIGITS-1:0][3:0]   bcd_q;
    logic [NUM_DIGITS-1:0]        err_q;
    logic                         fv_q;

    assign an_valid   = $onehot(~an_q);
    assign same       = ({an_q, seg_q} == {an_prev_q, seg_prev_q});
    assign complete   = &mask_q;
    assign cur_frame  = {slot_q, slot_err_q};
    assign frame_same = (cur_frame == last_q);

    // Run length of identical valid samples; capture once when it first reaches the target.
    always_comb begin
        cnt_d   = '0;
        capture = 1'b0;
        if (an_valid) begin
            // cnt_q != 0 implies the previous sample was valid as well
            if (same && cnt_q != '0) begin
                cnt_d = (cnt_q == SettleMax) ? SettleMax : cnt_q + 1'b1;
            end else begin
                cnt_d = CntW'(1);
            end
            capture = (cnt_d == SettleMax) && !(same && cnt_q == SettleMax);
        end
    end

    // Segment pattern to BCD; blank reads as F, anything unknown as E with error.
    always_comb begin
        dec_val = 4'hE;
        dec_err = 1'b1;
        case (seg_q)
            7'b1000000: begin dec_val = 4'h0; dec_err = 1'b0; end
            7'b1111001: begin dec_val = 4'h1; dec_err = 1'b0; end
            7'b0100100: begin dec_val = 4'h2; dec_err = 1'b0; end
            7'b0110000: begin dec_val = 4'h3; dec_err = 1'b0; end
            7'b0011001: begin dec_val = 4'h4; dec_err = 1'b0; end
            7'b0010010: begin dec_val = 4'h5; dec_err = 1'b0; end
            7'b0000010: begin dec_val = 4'h6; dec_err = 1'b0; end
            7'b1111000: begin dec_val = 4'h7; dec_err = 1'b0; end
            7'b0000000: begin dec_val = 4'h8; dec_err = 1'b0; end
            7'b0010000: begin dec_val = 4'h9; dec_err = 1'b0; end
            7'b1111111: begin dec_val = 4'hF; dec_err = 1'b0; end
            default:    begin dec_val = 4'hE; dec_err = 1'b1; end
        endcase
    end

    // Slot capture; a completed frame clears the mask so the next frame starts empty.
    always_comb begin
        slot_d     = slot_q;
        slot_err_d = slot_err_q;
        mask_d     = complete ? '0 : mask_q;
        if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!an_q[i]) begin
                    slot_d[i]     = dec_val;
                    slot_err_d[i] = dec_err;
                    mask_d[i]     = 1'b1;
                end
            end
        end
    end

    // Frame qualification; publish only on the transition into the stable state.
    always_comb begin
        stable_d = stable_q;
        publish  = 1'b0;
        if (complete) begin
            if (frame_same) begin
                stable_d = (stable_q == StableMax) ? StableMax : stable_q + 1'b1;
            end else begin
                stable_d = StbW'(1);
            end
            publish = (stable_d == StableMax) && !(frame_same && stable_q == StableMax);
        end
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            an_q       <= '0;
            seg_prev_q <= '0;
            an_prev_q  <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            slot_err_q <= '0;
            mask_q     <= '0;
            last_q     <= '0;
            stable_q   <= '0;
            bcd_q      <= '0;
            err_q      <= '0;
            fv_q       <= 1'b0;
        end else begin
            seg_q      <= seg_in;
            an_q       <= an_in;
            seg_prev_q <= seg_q;
            an_prev_q  <= an_q;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            slot_err_q <= slot_err_d;
            mask_q     <= mask_d;
            stable_q   <= stable_d;
            fv_q       <= publish;
            if (complete) begin
                last_q <= cur_frame;
            end
            if (publish) begin
                bcd_q <= slot_q;
                err_q <= slot_err_q;
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

endmodule
